// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state encoding and parity mode constants for the UART receiver
package uart_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_START  = 3'd1;
   localparam state_t ST_DATA   = 3'd2;
   localparam state_t ST_PARITY = 3'd3;
   localparam state_t ST_STOP   = 3'd4;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for an asynchronous input, resets to 1
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic meta;

   // Two-stage capture; reset to 1 so an idle-high line never looks like a start edge
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         meta <= 1'b1;
         o_q  <= 1'b1;
      end else begin
         meta <= i_d;
         o_q  <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with one-word hold register and sticky overrun
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_rx_serial,
   input  logic                 i_rx_ready,
   input  logic                 i_err_clr,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_rx_valid,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_break,
   output logic                 o_overrun
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

   logic                 rx_s;
   logic                 rx_prev;
   state_t               state;
   logic [BAUD_W-1:0]    baud_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_q;
   logic                 stop0_q;
   logic                 ferr_q;

   logic                 tick;
   logic                 frame_done;
   logic                 first_stop;
   logic                 new_ferr;
   logic                 new_perr;
   logic                 new_brk;
   logic                 par_x;
   logic                 pop;

   sync_2ff u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_rx_serial),
      .o_q     (rx_s)
   );

   // Previous synchronised level, for 1->0 start-edge detection
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) rx_prev <= 1'b1;
      else          rx_prev <= rx_s;
   end

   assign tick       = (baud_cnt == BAUD_LAST);
   assign frame_done = (state == ST_STOP) && tick && (bit_cnt == LAST_STOP);

   // Status of the completing frame, evaluated in the final stop-sample cycle
   always_comb begin
      first_stop = (bit_cnt == '0) ? rx_s : stop0_q;
      new_ferr   = ferr_q | ~rx_s;
      par_x      = (^shreg) ^ par_q;
      new_perr   = 1'b0;
      if (PARITY_MODE == PARITY_ODD)  new_perr = ~par_x;
      if (PARITY_MODE == PARITY_EVEN) new_perr = par_x;
      new_brk    = ~(|shreg) & ~first_stop &
                   ((PARITY_MODE == PARITY_NONE) ? 1'b1 : ~par_q);
   end

   // Receive FSM: start qualification at mid-bit, then one sample every bit period
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_q    <= 1'b0;
         stop0_q  <= 1'b1;
         ferr_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (rx_prev && !rx_s) state <= ST_START;
            end
            ST_START: begin
               if (baud_cnt == BAUD_HALF) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  ferr_q   <= 1'b0;
                  state    <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
               if (tick) begin
                  shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                  if (bit_cnt == LAST_DATA) begin
                     bit_cnt <= '0;
                     state   <= (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
               if (tick) begin
                  par_q   <= rx_s;
                  bit_cnt <= '0;
                  state   <= ST_STOP;
               end
            end
            ST_STOP: begin
               baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
               if (tick) begin
                  if (bit_cnt == '0) stop0_q <= rx_s;
                  ferr_q <= new_ferr;
                  if (bit_cnt == LAST_STOP) begin
                     bit_cnt <= '0;
                     state   <= ST_IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign pop = o_rx_valid & i_rx_ready;

   // Hold register: load when empty or popped this cycle, otherwise drop and flag overrun
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rx_data    <= '0;
         o_rx_valid   <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_break      <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         if (frame_done && (!o_rx_valid || pop)) begin
            o_rx_data    <= shreg;
            o_rx_valid   <= 1'b1;
            o_parity_err <= new_perr;
            o_frame_err  <= new_ferr;
            o_break      <= new_brk;
         end else if (pop) begin
            o_rx_valid   <= 1'b0;
         end

         if (frame_done && o_rx_valid && !pop) o_overrun <= 1'b1;
         else if (i_err_clr)                   o_overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed self-checking bench for uart_rx_cfg (8N1 and 8E1 instances)
module tb_uart_rx_cfg;
   import uart_pkg::*;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ser_n = 1'b1;
   logic       ser_e = 1'b1;
   logic       ready = 1'b0;
   logic       err_clr = 1'b0;

   logic [7:0] data_n, data_e;
   logic       valid_n, perr_n, ferr_n, brk_n, ovr_n;
   logic       valid_e, perr_e, ferr_e, brk_e, ovr_e;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_n (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(ser_n), .i_rx_ready(ready),
      .i_err_clr(err_clr), .o_rx_data(data_n), .o_rx_valid(valid_n),
      .o_parity_err(perr_n), .o_frame_err(ferr_n), .o_break(brk_n), .o_overrun(ovr_n)
   );

   uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) dut_e (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(ser_e), .i_rx_ready(ready),
      .i_err_clr(err_clr), .o_rx_data(data_e), .o_rx_valid(valid_e),
      .o_parity_err(perr_e), .o_frame_err(ferr_e), .o_break(brk_e), .o_overrun(ovr_e)
   );

   task automatic drive_bit(input bit sel_e, input logic v);
      if (sel_e) ser_e = v; else ser_n = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input bit sel_e, input logic [7:0] d, input bit has_par,
                             input logic par, input logic stop);
      drive_bit(sel_e, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(sel_e, d[i]);
      if (has_par) drive_bit(sel_e, par);
      drive_bit(sel_e, stop);
   endtask

   task automatic wait_valid(input bit sel_e, input string name);
      int n;
      n = 0;
      while (((sel_e ? valid_e : valid_n) !== 1'b1) && n < 64) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if ((sel_e ? valid_e : valid_n) !== 1'b1) begin
         $display("FAIL %s: o_rx_valid timeout, got %b want 1", name, sel_e ? valid_e : valid_n);
         n_fail++;
      end
   endtask

   task automatic pop_word();
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({valid_n, perr_n, ferr_n, brk_n, ovr_n, data_n} !== 13'h0) begin
         $display("FAIL reset_outputs: got %h want 0", {valid_n, perr_n, ferr_n, brk_n, ovr_n, data_n});
         n_fail++;
      end
      n_checks++;
      if (dut_n.state !== ST_IDLE) begin
         $display("FAIL reset_state: got %0d want %0d", dut_n.state, ST_IDLE);
         n_fail++;
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_8n1();
      send_frame(1'b0, 8'h56, 1'b0, 1'b0, 1'b1);
      wait_valid(1'b0, "8n1_valid");
      n_checks++;
      if (data_n !== 8'h56) begin $display("FAIL 8n1_data: got %h want 56", data_n); n_fail++; end
      n_checks++;
      if ({perr_n, ferr_n, brk_n, ovr_n} !== 4'b0) begin
         $display("FAIL 8n1_flags: got %b want 0000", {perr_n, ferr_n, brk_n, ovr_n}); n_fail++;
      end
      pop_word();
      n_checks++;
      if (valid_n !== 1'b0) begin $display("FAIL 8n1_pop: got %b want 0", valid_n); n_fail++; end
   endtask

   task automatic test_parity();
      // 0xA5 has four ones: even parity bit is 0, so sending 1 is an error
      send_frame(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
      wait_valid(1'b1, "8e1_valid");
      n_checks++;
      if (data_e !== 8'hA5) begin $display("FAIL 8e1_data: got %h want a5", data_e); n_fail++; end
      n_checks++;
      if (perr_e !== 1'b1) begin $display("FAIL 8e1_perr: got %b want 1", perr_e); n_fail++; end
      n_checks++;
      if ({ferr_e, brk_e} !== 2'b0) begin $display("FAIL 8e1_ferr_brk: got %b want 00", {ferr_e, brk_e}); n_fail++; end
      pop_word();
   endtask

   task automatic test_glitch();
      ser_n = 1'b0;
      repeat (4) @(negedge clk);
      ser_n = 1'b1;
      repeat (48) @(negedge clk);
      n_checks++;
      if (valid_n !== 1'b0) begin $display("FAIL glitch_valid: got %b want 0", valid_n); n_fail++; end
      n_checks++;
      if (dut_n.state !== ST_IDLE) begin $display("FAIL glitch_state: got %0d want %0d", dut_n.state, ST_IDLE); n_fail++; end
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
      wait_valid(1'b0, "glitch_next_valid");
      n_checks++;
      if (data_n !== 8'h3C) begin $display("FAIL glitch_next_data: got %h want 3c", data_n); n_fail++; end
      pop_word();
   endtask

   task automatic test_frame_err();
      send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
      ser_n = 1'b1;
      wait_valid(1'b0, "ferr_valid");
      n_checks++;
      if ({data_n, ferr_n, brk_n} !== {8'h81, 1'b1, 1'b0}) begin
         $display("FAIL ferr_81: got data %h ferr %b brk %b want 81 1 0", data_n, ferr_n, brk_n); n_fail++;
      end
      repeat (CPB) @(negedge clk);
      pop_word();
      send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      ser_n = 1'b1;
      wait_valid(1'b0, "break_valid");
      n_checks++;
      if ({data_n, ferr_n, brk_n} !== {8'h00, 1'b1, 1'b1}) begin
         $display("FAIL break_00: got data %h ferr %b brk %b want 00 1 1", data_n, ferr_n, brk_n); n_fail++;
      end
      repeat (CPB) @(negedge clk);
      pop_word();
   endtask

   task automatic test_back_to_back();
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
      send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      n_checks++;
      if ({valid_n, data_n, ovr_n} !== {1'b1, 8'h11, 1'b1}) begin
         $display("FAIL b2b_overrun: got valid %b data %h ovr %b want 1 11 1", valid_n, data_n, ovr_n); n_fail++;
      end
      pop_word();
      n_checks++;
      if ({valid_n, ovr_n} !== 2'b01) begin
         $display("FAIL b2b_pop: got valid %b ovr %b want 0 1", valid_n, ovr_n); n_fail++;
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ovr_n !== 1'b0) begin $display("FAIL b2b_err_clr: got %b want 0", ovr_n); n_fail++; end
   endtask

   task automatic test_reset_mid_frame();
      send_frame(1'b0, 8'h56, 1'b0, 1'b0, 1'b1);
      wait_valid(1'b0, "rst_pre_valid");
      // second 0x56 left unpopped; reset after its third data bit
      drive_bit(1'b0, 1'b0);
      drive_bit(1'b0, 1'b0);
      drive_bit(1'b0, 1'b1);
      drive_bit(1'b0, 1'b1);
      ser_n = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({valid_n, perr_n, ferr_n, brk_n, ovr_n, data_n} !== 13'h0) begin
         $display("FAIL mid_rst_outputs: got %h want 0", {valid_n, perr_n, ferr_n, brk_n, ovr_n, data_n}); n_fail++;
      end
      ser_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (48) @(negedge clk);
      n_checks++;
      if ((valid_n !== 1'b0) || (dut_n.state !== ST_IDLE)) begin
         $display("FAIL mid_rst_idle: got valid %b state %0d want 0 %0d", valid_n, dut_n.state, ST_IDLE); n_fail++;
      end
      send_frame(1'b0, 8'h9A, 1'b0, 1'b0, 1'b1);
      wait_valid(1'b0, "mid_rst_next_valid");
      n_checks++;
      if ({data_n, perr_n, ferr_n, brk_n, ovr_n} !== {8'h9A, 4'b0}) begin
         $display("FAIL mid_rst_next: got data %h flags %b want 9a 0000", data_n, {perr_n, ferr_n, brk_n, ovr_n}); n_fail++;
      end
      pop_word();
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868: clocks per serial bit (100 MHz / 115200); legal range 8 or more.
REQ-002 The block SHALL have parameter DATA_BITS, default 8: payload bits per frame; legal range 5..9.
REQ-003 The block SHALL have parameter PARITY_MODE, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 The block SHALL have parameter STOP_BITS, default 1: stop bits checked per frame; legal values 1 or 2.
REQ-005 The block SHALL have port i_clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port i_rst_n, input, width 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port i_rx_serial, input, width 1: asynchronous serial line; idles high.
REQ-008 The block SHALL have port i_rx_ready, input, width 1: consumer accepts the held word.
REQ-009 The block SHALL have port i_err_clr, input, width 1: one-cycle pulse that clears the sticky overrun flag.
REQ-010 The block SHALL have port o_rx_data, output, width DATA_BITS: received payload, LSB first on the wire.
REQ-011 The block SHALL have port o_rx_valid, output, width 1: the hold register is full.
REQ-012 The block SHALL have ports o_parity_err, o_frame_err and o_break, outputs, width 1 each: status qualified by o_rx_valid.
REQ-013 The block SHALL have port o_overrun, output, width 1: sticky flag, a frame was lost.

Function
REQ-014 i_rx_serial SHALL pass through a 2-FF synchroniser reset to 1; all logic SHALL use the synchronised bit only.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on a 1->0 transition of the synchronised bit.
REQ-016 START SHALL resample the line after (CLKS_PER_BIT-1)/2 cycles.
- Line low: go to DATA.
- Line high: false start, return to IDLE with no output change.
REQ-017 DATA, PARITY and STOP bits SHALL each be sampled exactly CLKS_PER_BIT cycles after the previous sample.
- DATA_BITS samples in DATA, shifted in LSB first.
- PARITY is skipped when PARITY_MODE = 0.
- STOP takes STOP_BITS samples.
REQ-018 Parity error SHALL be asserted when the XOR of the data bits and the parity bit is 0 for odd parity or 1 for even parity.
REQ-019 Frame error SHALL be asserted when any sampled stop bit is 0.
REQ-020 Break SHALL be asserted when all data bits, the parity bit (if present) and the first stop bit are all 0; break also sets the frame error.
REQ-021 After the final stop sample the FSM SHALL return to IDLE on the next cycle, so a start edge within half a bit is accepted (back-to-back frames).
REQ-022 On the cycle after the final stop sample, the block SHALL load payload and error flags into the hold register and set o_rx_valid.
REQ-023 Handshake: when o_rx_valid and i_rx_ready are both high in a cycle, the word SHALL be consumed and o_rx_valid SHALL fall next cycle unless a new word loads in that same cycle.
REQ-024 If a frame completes while o_rx_valid=1 and no pop occurs in that cycle, the new word SHALL be dropped, the held word kept, and o_overrun set.
REQ-025 A pop and a completion in the same cycle SHALL load the new word with o_rx_valid staying 1 and no overrun.
REQ-026 o_overrun SHALL stay set until i_err_clr; if i_err_clr and a new overrun occur in the same cycle, set wins.

Reset
REQ-027 Asserting i_rst_n low SHALL, asynchronously, force:
- FSM to IDLE and counters to 0;
- synchroniser to 1;
- o_rx_data to 0;
- o_rx_valid, o_parity_err, o_frame_err, o_break and o_overrun to 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL wait for a fresh falling edge.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state type and the PARITY_NONE/ODD/EVEN constants.
REQ-030 The synchroniser SHALL be a sub-module, sync_2ff, with a reset value of 1.
REQ-031 The bit counter and baud counter SHALL be sized with $clog2 of DATA_BITS and CLKS_PER_BIT.

Verification
REQ-032 The bench SHALL use CLKS_PER_BIT=16 and check these scenarios:
- 8N1 frame 0x56 -> o_rx_valid=1, o_rx_data=0x56, all error flags 0.
- 8E1 frame 0xA5 with parity bit forced to 1 -> o_rx_data=0xA5, o_parity_err=1.
- Low glitch of 4 clocks on an idle line -> no o_rx_valid; FSM returns to IDLE; a following 0x3C frame is received correctly.
- 8N1 frame 0x81 with stop bit 0 -> o_frame_err=1, o_break=0; an all-zero frame with stop 0 -> o_frame_err=1, o_break=1.
- Frames 0x11 then 0x22 back-to-back with i_rx_ready=0 -> o_rx_data=0x11, o_overrun=1; pop -> o_rx_valid=0; i_err_clr -> o_overrun=0.
- i_rst_n pulsed low after the third data bit of 0x56 -> all outputs 0; a next frame of 0x9A -> o_rx_data=0x9A, no errors.
